stopwatch_display: RTL
======================

# stopwatch_display

Display-side consumer of the stopwatch count and state outputs. Samples `minute`, `seconds` and `state` and converts the binary count to BCD with a sequential shift-add-3 engine. Drives a 5-digit multiplexed seven-segment display as MMM.SS, blinking while the stopwatch is paused. Sits beside the stopwatch top-level on the same clock and feeds the board display pins.

## Interface

Parameters:
- `SCAN_DIV`, default 1000: clk cycles each digit is held before the scan advances (≥2).
- `BLINK_DIV`, default 25_000_000: clk cycles per blink half-period while paused (≥2).

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (low = reset).
- `minute`  input  8  binary minutes, 0..255.
- `seconds`  input  6  binary seconds, 0..63 (nominally 0..59).
- `state`  input  2  stopwatch state: 2'b00 IDLE, 2'b01 RUNNING, 2'b10 PAUSED, 2'b11 treated as IDLE.
- `seg`  output  7  segments, active-high, `seg[0]`=a … `seg[6]`=g.
- `an`  output  5  one-hot digit enable, active-high. `an[0]`=seconds ones, `an[1]`=seconds tens, `an[2]`=minute ones, `an[3]`=minute tens, `an[4]`=minute hundreds.
- `dp`  output  1  separator point, high only while `an[2]` is active.

## Operation

- **Converter FSM**, free-running, states CV_CAP → CV_SHIFT → CV_LOAD → CV_CAP:
  - **CV_CAP** (1 cycle): capture `minute` and `{2'b00, seconds}` into two 8-bit shift registers; clear the two BCD accumulators (12-bit and 8-bit).
  - **CV_SHIFT** (exactly 8 cycles): on each cycle, add 3 to every BCD nibble ≥5, then shift left one bit with the binary MSB entering. Both channels run in parallel.
  - **CV_LOAD** (1 cycle): copy the accumulators into five 4-bit digit registers.
  - Conversion period is 10 cycles.
- **Scan**:
  - Prescaler counts 0..`SCAN_DIV`-1.
  - At terminal count, the digit index advances 0→1→2→3→4→0.
  - Registered outputs follow the index each cycle: `an` = one-hot(index), `seg` = encode(digit[index]), `dp` = (index==2).
- **Segment encoding** (hex, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Blank = 00.
- **Blink**:
  - While `state`==PAUSED, the blink counter runs 0..`BLINK_DIV`-1 and toggles `phase` at terminal count.
  - When `phase`=1, `an` = 5'b00000. `seg` and `dp` are still driven normally.
  - When not PAUSED, the counter and `phase` are held at 0.
- IDLE and RUNNING display identically. The display always shows the most recently converted value.

## Timing

- **Reset** (async assert; release is synchronous to `clk`):
  - Outputs: `seg`=0, `an`=0, `dp`=0.
  - Internal: digit registers=0, index=0, prescaler=0, blink counter=0, `phase`=0, converter in CV_CAP.
- **First edge after release**: `an`=5'b00001, `seg`=3F.
- **Input-to-digit latency**: ≤20 cycles from an input change to the digit registers (≤10 to the next CV_CAP, plus 10 to convert). Then ≤1 cycle to `seg`, if that digit is currently selected.
- **Mid-conversion changes**: input changes during CV_SHIFT/CV_LOAD are ignored until the next CV_CAP. The digit registers never hold a partial conversion.
- **Scan changes**: the index changes exactly every `SCAN_DIV` cycles; `an` follows 1 cycle later. Full refresh = 5×`SCAN_DIV` cycles.
- **PAUSED entry**: first blank occurs `BLINK_DIV` cycles after `state` becomes PAUSED.
- **PAUSED exit**: `phase` clears on the next edge; `an` is re-enabled 1 cycle later.
- **Reset mid-operation**: outputs clear immediately and asynchronously; no partial state survives.
- **Out-of-range seconds**: values 60..63 are displayed literally (e.g. 63 → "63"); no clamping.

## Configuration

- `STOPWATCH_DISP_LZB_EN` defined: leading-zero blanking.
  - Minute hundreds is blank when it is 0.
  - Minute tens is blank when hundreds and tens are both 0.
  - Minute ones and both seconds digits are never blank.
  - `an` still scans the blanked positions, with `seg`=00.
- Not defined: all five digits are always shown, including leading zeros.

## Test plan

1. Reset low 3 cycles, `minute`=0, `seconds`=0, `state`=IDLE, `SCAN_DIV`=4; release → next edge `an`=00001, `seg`=3F. At index 4: `seg`=00 with `STOPWATCH_DISP_LZB_EN`, 3F without.
2. `minute`=125, `seconds`=47 → within 20 cycles the digits are 1,2,5,4,7. Scan gives:
   - `an[0]`: `seg`=07
   - `an[1]`: `seg`=66
   - `an[2]`: `seg`=6D, `dp`=1
   - `an[3]`: `seg`=5B
   - `an[4]`: `seg`=06
3. `minute`=255, `seconds`=59 → digits 2,5,5,5,9. Then `minute`=0, `seconds`=0 → all digits 0 within 20 cycles.
4. `BLINK_DIV`=8, `state`=PAUSED → `an` active for 8 cycles, 00000 for 8, repeating. Set `state`=RUNNING while blanked → `an` non-zero within 2 cycles.
5. Change `minute` from 10 to 99 one cycle after CV_CAP → digit registers show 10 first, then 99 within 20 cycles. No intermediate value ever appears.
6. Assert reset mid-scan at index 3 → `seg`, `an`, `dp` go to 0 without a clock edge. After release, scan restarts at index 0.

Source files
------------

// File: rtl/stopwatch_display.sv
// stopwatch_display: samples the stopwatch minute/second count and state, converts the
// binary count to BCD with a sequential shift-add-3 engine, and drives a 5-digit
// multiplexed seven-segment display as MMM.SS that blinks while the stopwatch is paused.
// Optional feature macro: STOPWATCH_DISP_LZB_EN enables leading-zero blanking of the
// minute hundreds/tens digits.
module stopwatch_display #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] minute,
    input  logic [5:0] seconds,
    input  logic [1:0] state,
    output logic [6:0] seg,
    output logic [4:0] an,
    output logic       dp
);

    localparam int unsigned ScanW  = $clog2(SCAN_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV);
    localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    localparam logic [1:0] StatePaused = 2'b10;

    typedef enum logic [1:0] {
        CvCap,
        CvShift,
        CvLoad
    } cv_state_e;

    // Converter state
    cv_state_e        cv_q, cv_d;
    logic [2:0]       shift_cnt_q, shift_cnt_d;
    logic [7:0]       min_bin_q, min_bin_d;
    logic [7:0]       sec_bin_q, sec_bin_d;
    logic [11:0]      min_acc_q, min_acc_d;
    logic [7:0]       sec_acc_q, sec_acc_d;
    logic [11:0]      min_adj;
    logic [7:0]       sec_adj;

    // Digit registers: [0] sec ones, [1] sec tens, [2] min ones, [3] min tens, [4] min hundreds
    logic [4:0][3:0]  digit_q, digit_d;

    // Scan and blink state
    logic [ScanW-1:0]  presc_q, presc_d;
    logic [2:0]        idx_q, idx_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic              phase_q, phase_d;
    logic              paused;

    // Output registers
    logic [6:0] seg_q, seg_d;
    logic [4:0] an_q, an_d;
    logic       dp_q, dp_d;
    logic [3:0] cur_digit;
    logic       blank;

    // Add 3 to a BCD nibble that would overflow past 9 after the next shift.
    function automatic logic [3:0] bcd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Seven-segment encoding, gfedcba, active-high; non-decimal codes show blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Converter: next state and shift-add-3 datapath
    always_comb begin
        cv_d        = cv_q;
        shift_cnt_d = shift_cnt_q;
        min_bin_d   = min_bin_q;
        sec_bin_d   = sec_bin_q;
        min_acc_d   = min_acc_q;
        sec_acc_d   = sec_acc_q;
        digit_d     = digit_q;
        min_adj     = {bcd_adj(min_acc_q[11:8]), bcd_adj(min_acc_q[7:4]),
                       bcd_adj(min_acc_q[3:0])};
        sec_adj     = {bcd_adj(sec_acc_q[7:4]), bcd_adj(sec_acc_q[3:0])};
        unique case (cv_q)
            CvCap: begin
                min_bin_d   = minute;
                sec_bin_d   = {2'b00, seconds};
                min_acc_d   = '0;
                sec_acc_d   = '0;
                shift_cnt_d = '0;
                cv_d        = CvShift;
            end
            CvShift: begin
                min_acc_d   = {min_adj[10:0], min_bin_q[7]};
                sec_acc_d   = {sec_adj[6:0], sec_bin_q[7]};
                min_bin_d   = {min_bin_q[6:0], 1'b0};
                sec_bin_d   = {sec_bin_q[6:0], 1'b0};
                shift_cnt_d = shift_cnt_q + 3'd1;
                if (shift_cnt_q == 3'd7) begin
                    cv_d = CvLoad;
                end
            end
            CvLoad: begin
                // Digits update only here, so they never show a partial conversion.
                digit_d = {min_acc_q[11:8], min_acc_q[7:4], min_acc_q[3:0],
                           sec_acc_q[7:4], sec_acc_q[3:0]};
                cv_d    = CvCap;
            end
            default: begin
                cv_d = CvCap;
            end
        endcase
    end

    // Converter and digit registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cv_q        <= CvCap;
            shift_cnt_q <= '0;
            min_bin_q   <= '0;
            sec_bin_q   <= '0;
            min_acc_q   <= '0;
            sec_acc_q   <= '0;
            digit_q     <= '0;
        end else begin
            cv_q        <= cv_d;
            shift_cnt_q <= shift_cnt_d;
            min_bin_q   <= min_bin_d;
            sec_bin_q   <= sec_bin_d;
            min_acc_q   <= min_acc_d;
            sec_acc_q   <= sec_acc_d;
            digit_q     <= digit_d;
        end
    end

    // Scan prescaler/index and pause blink counter next state
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == ScanLast) begin
            presc_d = '0;
            idx_d   = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end

        paused  = (state == StatePaused);
        blink_d = '0;
        phase_d = 1'b0;
        if (paused) begin
            phase_d = phase_q;
            if (blink_q == BlinkLast) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end
    end

    // Scan and blink registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end

    // Output next state: selected digit encoding, one-hot enable, separator point
    always_comb begin
        cur_digit = digit_q[idx_q];
`ifdef STOPWATCH_DISP_LZB_EN
        blank = ((idx_q == 3'd4) && (digit_q[4] == 4'd0)) ||
                ((idx_q == 3'd3) && (digit_q[4] == 4'd0) && (digit_q[3] == 4'd0));
`else
        blank = 1'b0;
`endif
        seg_d = blank ? 7'h00 : seg_encode(cur_digit);
        an_d  = phase_q ? 5'b00000 : (5'b00001 << idx_q);
        dp_d  = (idx_q == 3'd2);
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q <= '0;
            an_q  <= '0;
            dp_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule
